hps_ext_cmdq: RTL and testbench
===============================

// Module: hps_ext_cmdq
// PURPOSE
// - Parametrised successor of the Groovy HPS extension-bus endpoint. Decodes HPS
//   commands on EXT_BUS, returns an atomic status snapshot, holds config registers
//   and fires one-cycle pulses.
// - Blit commands go into a FIFO, so HPS can queue several LZ4/raw blits ahead of
//   the blitter. This replaces the single pending flag.
// - Sits between hps_io's EXT_BUS and the PoC core in the sys_top wrapper.
// PARAMETERS
// - CMD_BASE      'hF0  first command code; codes CMD_BASE+0..+4 are owned
// - NUM_STATUS    10    16-bit status words returned by GET_STATUS (1..30)
// - NUM_CFG       4     16-bit writable config registers (1..16)
// - QDEPTH        4     blit-queue entries; power of two, 2..16
// PORTS
// - clk_sys     in   1               system clock; all logic on posedge
// - reset       in   1               synchronous, active-high
// - EXT_BUS     io   36              [15:0] dout, [31:16] din, [32] dout_en, [33] strobe, [34] enable
// - hps_event   in   1               toggle; each edge increments evt_cnt
// - status_in   in   NUM_STATUS*16   live status words; word i = [16i+15:16i]
// - cfg_out     out  NUM_CFG*16      config registers
// - pulse_out   out  16              one-cycle command pulses
// - blit_valid  out  1               queue head valid
// - blit_ready  in   1               consumer pops the head when valid&ready
// - blit_flags  out  16              head entry flags (bit0 = A/B buffer)
// - blit_size   out  32              head entry byte count
// - q_level     out  $clog2(QDEPTH)+1  occupancy
// - q_overflow  out  1               sticky; set when a push is dropped
// BEHAVIOUR
// - Reset: all outputs 0; dout_en=0; evt_cnt=0; queue empty; q_overflow=0.
// - Bus framing
//   - enable=0: dout_en=0, io_dout=0, wcnt=0, cmd=0.
//   - Each strobe while enable=1: io_dout registered that edge and held to the next strobe.
//   - wcnt is 5 bits, increments per strobe and saturates at 31.
// - Word 0 (wcnt=0)
//   - Latches cmd=din.
//   - dout_en=1 iff CMD_BASE<=din<=CMD_BASE+4.
//   - io_dout={8'd0,evt_cnt} for owned codes, else 0.
// - GET_STATUS (+0)
//   - At wcnt=1: io_dout=status_in word 0 (live), and the same edge snapshots all of status_in.
//   - wcnt=k, 2<=k<=NUM_STATUS: io_dout=snapshot word k-1.
//   - wcnt=NUM_STATUS+1: io_dout={q_overflow,q_level,...zero-pad}.
//   - Beyond that: 0 (subject to checksum option).
// - GET_CONFIG (+1): wcnt=k, 1<=k<=NUM_CFG: io_dout=cfg reg k-1; else 0.
// - SET_CONFIG (+2)
//   - wcnt=1: latch index=din[3:0].
//   - wcnt=2: write cfg[index]=din if index<NUM_CFG; else ignored.
//   - Further words alternate index/value pairs (odd=index, even=value).
// - SET_PULSE (+3): wcnt=1: pulse_out=din for exactly one clk_sys cycle, then 0.
// - SET_BLIT_Q (+4)
//   - wcnt=1: staged flags. wcnt=2: size[15:0]. wcnt=3: size[31:16] and push.
//   - Push when full: entry dropped, q_overflow<=1.
//   - enable falling before wcnt=3: staged entry discarded, nothing pushed.
//   - q_overflow clears only on reset or a SET_PULSE with din[15]=1.
//   - Queue is a show-ahead FIFO: blit_flags/blit_size valid while blit_valid.
//   - Pop and push in the same cycle: allowed, including when full; level unchanged, no overflow.
//   - Pop when empty: ignored.
// - evt_cnt: 8 bits, wraps 255->0. Edge detect on a registered copy of hps_event.
// - Reset mid-transaction: aborts the command and clears the queue. Bus resumes at the
//   next enable rising.
// CONFIGURATION
// - HPS_EXT_CHECKSUM_EN defined
//   - GET_STATUS wcnt=NUM_STATUS+2 returns the XOR of snapshot words 0..NUM_STATUS-1
//     and the level/overflow word.
//   - Accumulated as the words are shifted out; no extra combinational XOR tree.
// - Undefined: that word reads 0 and no checksum logic is generated.
// STRUCTURE
// - hps_ext_pkg: command offsets (CMD_GET_STATUS..CMD_SET_BLIT_Q), EXT_BUS bit indices,
//   typedef blit_entry_t {flags[15:0], size[31:0]}.
// - Sub-module hps_ext_fifo: parametrised show-ahead FIFO (width 48, depth QDEPTH).
//   - Handles push/pop/full/empty/level.
//   - Full-with-pop push is accepted.
// - Top level: bus framing, decode, snapshot, config regs, pulse, overflow flag.
// TESTING
// - Framing and count: toggle hps_event 3x, then GET_STATUS ('hF0).
//   -> word0 = 3, dout_en=1. Code 'hE0 -> dout_en=0, io_dout=0.
// - Atomic snapshot: status_in word1 changes 0x1111->0x2222 between strobes 1 and 2.
//   -> word 2 reads 0x1111.
// - Queue fill (QDEPTH=4, blit_ready=0): 5x SET_BLIT_Q size=0x0001_0000+n.
//   -> q_level=4, q_overflow=1, head size=0x0001_0000.
// - Full with simultaneous pop: queue full, pop on the push cycle.
//   -> level stays 4, q_overflow unchanged, new tail stored.
// - Config and pulse: SET_CONFIG idx2=0xBEEF, idx9 ignored.
//   -> GET_CONFIG word3=0xBEEF. SET_PULSE 0x8005 -> pulse_out=0x8005 for 1 cycle,
//      q_overflow cleared.
// - Abort: enable dropped after SET_BLIT_Q word2 -> no push. Checksum build: known words
//   -> XOR word matches the reference model.

Source files
------------

// File: rtl/hps_ext_pkg.sv
// Shared definitions for the HPS extension-bus command endpoint:
// command offsets, EXT_BUS bit positions, blit queue entry layout.
package hps_ext_pkg;

  // Command codes are CMD_BASE + offset
  localparam logic [15:0] CMD_GET_STATUS = 16'd0;
  localparam logic [15:0] CMD_GET_CONFIG = 16'd1;
  localparam logic [15:0] CMD_SET_CONFIG = 16'd2;
  localparam logic [15:0] CMD_SET_PULSE  = 16'd3;
  localparam logic [15:0] CMD_SET_BLIT_Q = 16'd4;
  localparam logic [15:0] CMD_COUNT      = 16'd5;

  // Bit positions within the flat 36-bit EXT_BUS of hps_io
  localparam int EXT_DOUT_LSB = 0;
  localparam int EXT_DIN_LSB  = 16;
  localparam int EXT_DOUT_EN  = 32;
  localparam int EXT_STROBE   = 33;
  localparam int EXT_ENABLE   = 34;
  localparam int EXT_W        = 36;

  typedef struct packed {
    logic [15:0] flags;
    logic [31:0] size;
  } blit_entry_t;

  // Bus framing only resumes once enable has been seen low
  typedef enum logic {ST_WAIT_IDLE, ST_ARMED} bus_state_e;

  // Unsigned offset of a code from the base; owned iff result < CMD_COUNT
  function automatic logic [15:0] cmd_offset(input logic [15:0] code, input logic [15:0] base);
    return code - base;
  endfunction

endpackage

// File: rtl/hps_ext_if.sv
// EXT_BUS handshake between hps_io (master) and the command endpoint (slave).
interface hps_ext_if;
  logic [15:0] dout;
  logic [15:0] din;
  logic        dout_en;
  logic        strobe;
  logic        enable;

  modport master (output din, strobe, enable, input dout, dout_en);
  modport slave  (input din, strobe, enable, output dout, dout_en);
endinterface

// File: rtl/hps_ext_fifo.sv
// Show-ahead FIFO for queued blit requests. A push while full is accepted
// when a pop happens in the same cycle; otherwise it is reported on drop.
module hps_ext_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          drop,
  output logic [AW:0]   level
);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;
  localparam logic [AW:0]   LVL_MAX = DEPTH;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic                    full, do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_MAX);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign dout    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end

  // storage; full+pop writes the slot being vacated, which becomes the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/hps_ext_cmdq.sv
// HPS extension-bus endpoint: command decode, atomic status snapshot,
// config registers, one-cycle pulses and a queued blit request FIFO.
// Optional: define HPS_EXT_CHECKSUM_EN to append an XOR checksum word
// after the level/overflow word of GET_STATUS.
module hps_ext_cmdq import hps_ext_pkg::*; #(
  parameter logic [15:0] CMD_BASE   = 16'hF0,
  parameter int          NUM_STATUS = 10,
  parameter int          NUM_CFG    = 4,
  parameter int          QDEPTH     = 4,
  localparam int         LW         = $clog2(QDEPTH) + 1
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  hps_ext_if.slave                ext_bus,
  input  logic                    hps_event,
  input  logic [NUM_STATUS*16-1:0] status_in,
  output logic [NUM_CFG*16-1:0]   cfg_out,
  output logic [15:0]             pulse_out,
  output logic                    blit_valid,
  input  logic                    blit_ready,
  output logic [15:0]             blit_flags,
  output logic [31:0]             blit_size,
  output logic [LW-1:0]           q_level,
  output logic                    q_overflow
);
  bus_state_e                  state, state_nxt;
  logic [15:0]                 cmd, off_cmd, off_din;
  logic [4:0]                  wcnt;
  logic [NUM_STATUS-1:0][15:0] snap;
  logic [NUM_CFG-1:0][15:0]    cfg;
  logic [3:0]                  cfg_idx;
  logic [7:0]                  evt_cnt;
  logic                        evt_q;
  logic [15:0]                 flags_stg, size_lo_stg;
  logic [15:0]                 lvl_word, rd_word;
  logic                        stb, push, drop, empty;
  blit_entry_t                 head, tail;
`ifdef HPS_EXT_CHECKSUM_EN
  logic [15:0]                 csum;
`endif

  assign off_cmd  = cmd_offset(cmd, CMD_BASE);
  assign off_din  = cmd_offset(ext_bus.din, CMD_BASE);
  assign stb      = ext_bus.enable & ext_bus.strobe & (state == ST_ARMED);
  assign push     = stb && (off_cmd == CMD_SET_BLIT_Q) && (wcnt == 5'd3);
  assign lvl_word = {q_overflow, q_level, {(15-LW){1'b0}}};
  assign tail     = '{flags: flags_stg, size: {ext_bus.din, size_lo_stg}};
  assign cfg_out  = cfg;

  // state register: after reset wait for enable low before accepting strobes
  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_WAIT_IDLE;
    else       state <= state_nxt;
  end

  // next state: any idle bus arms the framer
  always_comb begin
    state_nxt = state;
    if (!ext_bus.enable) state_nxt = ST_ARMED;
  end

  // read-data mux for the word following the current one
  always_comb begin
    rd_word = '0;
    if (off_cmd == CMD_GET_STATUS) begin
      if (wcnt == 5'd1) rd_word = status_in[15:0];
      else if (int'(wcnt) == NUM_STATUS + 1) rd_word = lvl_word;
`ifdef HPS_EXT_CHECKSUM_EN
      else if (int'(wcnt) == NUM_STATUS + 2) rd_word = csum;
`endif
      else begin
        for (int i = 1; i < NUM_STATUS; i++)
          if (int'(wcnt) == i + 1) rd_word = snap[i];
      end
    end else if (off_cmd == CMD_GET_CONFIG) begin
      for (int i = 0; i < NUM_CFG; i++)
        if (int'(wcnt) == i + 1) rd_word = cfg[i];
    end
  end

  // bus framing, decode, snapshot, config writes, pulses and blit staging
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd             <= '0;
      wcnt            <= '0;
      ext_bus.dout    <= '0;
      ext_bus.dout_en <= 1'b0;
      snap            <= '0;
      cfg             <= '0;
      cfg_idx         <= '0;
      flags_stg       <= '0;
      size_lo_stg     <= '0;
      pulse_out       <= '0;
    end else begin
      pulse_out <= '0;
      if (!ext_bus.enable) begin
        cmd             <= '0;
        wcnt            <= '0;
        ext_bus.dout    <= '0;
        ext_bus.dout_en <= 1'b0;
      end else if (stb) begin
        if (wcnt != 5'd31) wcnt <= wcnt + 5'd1;
        if (wcnt == 5'd0) begin
          cmd             <= ext_bus.din;
          ext_bus.dout_en <= (off_din < CMD_COUNT);
          ext_bus.dout    <= (off_din < CMD_COUNT) ? {8'd0, evt_cnt} : 16'd0;
        end else begin
          ext_bus.dout <= rd_word;
          if (off_cmd == CMD_GET_STATUS && wcnt == 5'd1) snap <= status_in;
          if (off_cmd == CMD_SET_CONFIG) begin
            if (wcnt[0]) cfg_idx <= ext_bus.din[3:0];
            else begin
              for (int i = 0; i < NUM_CFG; i++)
                if (cfg_idx == 4'(i)) cfg[i] <= ext_bus.din;
            end
          end
          if (off_cmd == CMD_SET_PULSE && wcnt == 5'd1) pulse_out <= ext_bus.din;
          if (off_cmd == CMD_SET_BLIT_Q && wcnt == 5'd1) flags_stg   <= ext_bus.din;
          if (off_cmd == CMD_SET_BLIT_Q && wcnt == 5'd2) size_lo_stg <= ext_bus.din;
        end
      end
    end
  end

  // sticky overflow; cleared by a SET_PULSE carrying bit 15
  always_ff @(posedge clk_sys) begin
    if (reset) q_overflow <= 1'b0;
    else if (drop) q_overflow <= 1'b1;
    else if (stb && off_cmd == CMD_SET_PULSE && wcnt == 5'd1 && ext_bus.din[15])
      q_overflow <= 1'b0;
  end

  // event counter; reset loads the current level so no false edge follows
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      evt_q   <= hps_event;
      evt_cnt <= '0;
    end else begin
      evt_q <= hps_event;
      if (hps_event ^ evt_q) evt_cnt <= evt_cnt + 8'd1;
    end
  end

`ifdef HPS_EXT_CHECKSUM_EN
  // running XOR of each GET_STATUS word as it is shifted out
  always_ff @(posedge clk_sys) begin
    if (reset) csum <= '0;
    else if (stb && off_cmd == CMD_GET_STATUS && wcnt != 5'd0 && int'(wcnt) <= NUM_STATUS + 1)
      csum <= (wcnt == 5'd1) ? rd_word : (csum ^ rd_word);
  end
`endif

  hps_ext_fifo #(.W($bits(blit_entry_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .din   (tail),
    .pop   (blit_ready),
    .dout  (head),
    .empty (empty),
    .drop  (drop),
    .level (q_level)
  );

  assign blit_valid = ~empty;
  assign blit_flags = blit_valid ? head.flags : 16'd0;
  assign blit_size  = blit_valid ? head.size  : 32'd0;
endmodule

// File: tb/tb_hps_ext_cmdq.sv
// Scoreboard bench for hps_ext_cmdq: expected bus words are queued as each
// strobe is driven and compared against the captured dout/dout_en.
module tb_hps_ext_cmdq;
  import hps_ext_pkg::*;

  localparam int NS = 10;
  localparam int NC = 4;
  localparam int QD = 4;
  localparam logic [16:0] W0 = 17'h1_0000;  // owned, data 0
  localparam logic [16:0] Z0 = 17'h0_0000;  // not owned

  logic                 clk_sys = 1'b0;
  logic                 reset = 1'b1;
  logic                 hps_event = 1'b0;
  logic                 blit_ready = 1'b0;
  logic [NS*16-1:0]     status_in = '0;
  logic [NC*16-1:0]     cfg_out;
  logic [15:0]          pulse_out;
  logic                 blit_valid;
  logic [15:0]          blit_flags;
  logic [31:0]          blit_size;
  logic [2:0]           q_level;
  logic                 q_overflow;

  hps_ext_if bus();

  hps_ext_cmdq #(.CMD_BASE(16'hF0), .NUM_STATUS(NS), .NUM_CFG(NC), .QDEPTH(QD)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ext_bus    (bus),
    .hps_event  (hps_event),
    .status_in  (status_in),
    .cfg_out    (cfg_out),
    .pulse_out  (pulse_out),
    .blit_valid (blit_valid),
    .blit_ready (blit_ready),
    .blit_flags (blit_flags),
    .blit_size  (blit_size),
    .q_level    (q_level),
    .q_overflow (q_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  logic [16:0]  exp_q[$];
  logic [16:0]  obs_q[$];
  blit_entry_t  model_q[$];
  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [7:0]   evt_exp = 8'd0;
  logic         m_ovf = 1'b0;

  function automatic logic [16:0] own_word0();
    return {1'b1, 8'd0, evt_exp};
  endfunction

  task automatic xfer(input logic [15:0] d, input logic [16:0] e, input logic rdy);
    @(negedge clk_sys);
    bus.din = d; bus.strobe = 1'b1; blit_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk_sys);
    bus.strobe = 1'b0; blit_ready = 1'b0;
    obs_q.push_back({bus.dout_en, bus.dout});
  endtask

  task automatic bus_open();
    @(negedge clk_sys);
    bus.enable = 1'b1;
  endtask

  task automatic bus_close();
    @(negedge clk_sys);
    bus.enable = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic blit_cmd(input logic [15:0] fl, input logic [31:0] sz, input logic rdy);
    blit_entry_t tmp;
    bus_open();
    xfer(16'hF4, own_word0(), 1'b0);
    xfer(fl, W0, 1'b0);
    xfer(sz[15:0], W0, 1'b0);
    xfer(sz[31:16], W0, rdy);
    bus_close();
    if (rdy && model_q.size() > 0) tmp = model_q.pop_front();
    if (model_q.size() < QD) model_q.push_back('{flags: fl, size: sz});
    else m_ovf = 1'b1;
  endtask

  // word1 changes between strobes 1 and 2 to exercise the atomic snapshot
  task automatic get_status(input logic [15:0] lvlw);
    logic [15:0] orig [NS];
    logic [15:0] cs_exp;
    for (int i = 0; i < NS; i++) begin
      orig[i] = (i == 1) ? 16'h1111 : 16'h1000 + 16'(i);
      status_in[16*i +: 16] = orig[i];
    end
    bus_open();
    xfer(16'hF0, own_word0(), 1'b0);
    xfer(16'h0, {1'b1, orig[0]}, 1'b0);
    for (int i = 0; i < NS; i++)
      status_in[16*i +: 16] = (i == 1) ? 16'h2222 : ~orig[i];
    for (int k = 2; k <= NS; k++) xfer(16'h0, {1'b1, orig[k-1]}, 1'b0);
    xfer(16'h0, {1'b1, lvlw}, 1'b0);
`ifdef HPS_EXT_CHECKSUM_EN
    cs_exp = lvlw;
    for (int i = 0; i < NS; i++) cs_exp = cs_exp ^ orig[i];
`else
    cs_exp = 16'h0;
`endif
    xfer(16'h0, {1'b1, cs_exp}, 1'b0);
    xfer(16'h0, W0, 1'b0);
    bus_close();
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.strobe = 1'b0; bus.din = 16'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    vec_cnt++; if ({bus.dout_en, bus.dout} !== Z0) begin err_cnt++; $display("FAIL reset_bus got %h want %h", {bus.dout_en, bus.dout}, Z0); end
    vec_cnt++; if (cfg_out !== '0) begin err_cnt++; $display("FAIL reset_cfg got %h want 0", cfg_out); end
    vec_cnt++; if ({blit_valid, q_level, q_overflow, pulse_out} !== '0) begin err_cnt++; $display("FAIL reset_q got v=%b l=%0d o=%b p=%h want all 0", blit_valid, q_level, q_overflow, pulse_out); end
  endtask

  task automatic test_framing();
    logic [16:0] e, o;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys); hps_event = ~hps_event;
      @(negedge clk_sys); @(negedge clk_sys);
    end
    evt_exp = 8'd3;
    get_status(16'h0000);
    bus_open();
    xfer(16'hE0, Z0, 1'b0);
    xfer(16'h1234, Z0, 1'b0);
    bus_close();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL framing word %0d got %h want %h", n, o, e); end
      n++;
    end
    vec_cnt++; if ({bus.dout_en, bus.dout} !== Z0) begin err_cnt++; $display("FAIL idle_bus got %h want %h", {bus.dout_en, bus.dout}, Z0); end
  endtask

  task automatic test_config();
    logic [16:0] e, o;
    int n = 0;
    bus_open();
    xfer(16'hF2, own_word0(), 1'b0);
    xfer(16'd2, W0, 1'b0); xfer(16'hBEEF, W0, 1'b0);
    xfer(16'd9, W0, 1'b0); xfer(16'h1234, W0, 1'b0);
    xfer(16'd0, W0, 1'b0); xfer(16'hA5A5, W0, 1'b0);
    bus_close();
    bus_open();
    xfer(16'hF1, own_word0(), 1'b0);
    xfer(16'h0, {1'b1, 16'hA5A5}, 1'b0);
    xfer(16'h0, W0, 1'b0);
    xfer(16'h0, {1'b1, 16'hBEEF}, 1'b0);
    xfer(16'h0, W0, 1'b0);
    xfer(16'h0, W0, 1'b0);
    bus_close();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL config word %0d got %h want %h", n, o, e); end
      n++;
    end
    vec_cnt++; if (cfg_out !== {16'h0, 16'hBEEF, 16'h0, 16'hA5A5}) begin err_cnt++; $display("FAIL cfg_out got %h want 0000beef0000a5a5", cfg_out); end
  endtask

  task automatic test_queue_fill();
    logic [16:0] e, o;
    int n = 0;
    for (int i = 0; i < 5; i++) blit_cmd(16'(i), 32'h0001_0000 + i, 1'b0);
    @(negedge clk_sys);
    vec_cnt++; if (q_level !== 3'(model_q.size()) || q_overflow !== m_ovf) begin err_cnt++; $display("FAIL fill_level got l=%0d o=%b want l=%0d o=%b", q_level, q_overflow, model_q.size(), m_ovf); end
    vec_cnt++; if (blit_valid !== 1'b1 || blit_size !== model_q[0].size || blit_flags !== model_q[0].flags) begin err_cnt++; $display("FAIL fill_head got v=%b f=%h s=%h want f=%h s=%h", blit_valid, blit_flags, blit_size, model_q[0].flags, model_q[0].size); end
    get_status({m_ovf, 3'(model_q.size()), 12'h0});
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL fill_status word %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_pulse();
    logic [16:0] e, o;
    bus_open();
    xfer(16'hF3, own_word0(), 1'b0);
    @(negedge clk_sys);
    bus.din = 16'h8005; bus.strobe = 1'b1; exp_q.push_back(W0);
    @(negedge clk_sys);
    bus.strobe = 1'b0; obs_q.push_back({bus.dout_en, bus.dout});
    m_ovf = 1'b0;
    vec_cnt++; if (pulse_out !== 16'h8005) begin err_cnt++; $display("FAIL pulse_hi got %h want 8005", pulse_out); end
    vec_cnt++; if (q_overflow !== m_ovf) begin err_cnt++; $display("FAIL pulse_ovf_clr got %b want %b", q_overflow, m_ovf); end
    @(negedge clk_sys);
    vec_cnt++; if (pulse_out !== 16'h0) begin err_cnt++; $display("FAIL pulse_lo got %h want 0", pulse_out); end
    bus_close();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL pulse_bus got %h want %h", o, e); end
    end
  endtask

  task automatic test_full_pop();
    blit_entry_t h;
    blit_cmd(16'h0009, 32'h0001_0009, 1'b1);
    vec_cnt++; if (q_level !== 3'(model_q.size()) || q_overflow !== m_ovf) begin err_cnt++; $display("FAIL fullpop_level got l=%0d o=%b want l=%0d o=%b", q_level, q_overflow, model_q.size(), m_ovf); end
    while (model_q.size() > 0) begin
      @(negedge clk_sys);
      h = model_q.pop_front(); vec_cnt++;
      if (blit_valid !== 1'b1 || blit_flags !== h.flags || blit_size !== h.size) begin err_cnt++; $display("FAIL drain_head got v=%b f=%h s=%h want f=%h s=%h", blit_valid, blit_flags, blit_size, h.flags, h.size); end
      blit_ready = 1'b1;
      @(negedge clk_sys);
      blit_ready = 1'b0;
    end
    @(negedge clk_sys); blit_ready = 1'b1;
    @(negedge clk_sys); blit_ready = 1'b0;
    vec_cnt++; if ({blit_valid, q_level, blit_size} !== '0) begin err_cnt++; $display("FAIL pop_empty got v=%b l=%0d s=%h want 0", blit_valid, q_level, blit_size); end
  endtask

  task automatic test_abort();
    logic [16:0] e, o;
    blit_entry_t h;
    bus_open();
    xfer(16'hF4, own_word0(), 1'b0);
    xfer(16'h0007, W0, 1'b0);
    xfer(16'h0007, W0, 1'b0);
    bus_close();
    vec_cnt++; if (q_level !== 3'd0 || blit_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_nopush got l=%0d v=%b want l=0 v=0", q_level, blit_valid); end
    blit_cmd(16'h0003, 32'h0005_0006, 1'b0);
    h = model_q[0];
    vec_cnt++; if (q_level !== 3'(model_q.size()) || blit_flags !== h.flags || blit_size !== h.size) begin err_cnt++; $display("FAIL abort_next got l=%0d f=%h s=%h want l=%0d f=%h s=%h", q_level, blit_flags, blit_size, model_q.size(), h.flags, h.size); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL abort_bus got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_abort();
    logic [16:0] e, o;
    int n = 0;
    bus_open();
    xfer(16'hF4, own_word0(), 1'b0);
    xfer(16'h0001, W0, 1'b0);
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); @(negedge clk_sys); reset = 1'b0;
    evt_exp = 8'd0; model_q.delete(); m_ovf = 1'b0;
    vec_cnt++; if ({blit_valid, q_level, q_overflow} !== '0 || cfg_out !== '0) begin err_cnt++; $display("FAIL rst_mid got v=%b l=%0d o=%b cfg=%h want 0", blit_valid, q_level, q_overflow, cfg_out); end
    xfer(16'hF1, Z0, 1'b0);
    bus_close();
    bus_open();
    xfer(16'hF1, own_word0(), 1'b0);
    xfer(16'h0, W0, 1'b0);
    bus_close();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL rst_mid_bus word %0d got %h want %h", n, o, e); end
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_framing();
    test_config();
    test_queue_fill();
    test_pulse();
    test_full_pop();
    test_abort();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
